// File: rtl/ifetch_cached_bp.sv
// Instruction fetch with a direct-mapped I-cache and a bimodal 2-bit BHT; one instruction per cycle,
// 1-cycle hit latency, refill via a held request; stall/redirect block issue, rdy=0 freezes all state.
module ifetch_cached_bp #(
   parameter int ADDR_W      = 32,
   parameter int NUM_BLKS    = 16,
   parameter int BLK_WORDS   = 16,
   parameter int BHT_ENTRIES = 256,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    stall,
   input  logic                    redirect_valid,
   input  logic [ADDR_W-1:0]       redirect_pc,
   input  logic                    bp_upd_valid,
   input  logic [ADDR_W-1:0]       bp_upd_pc,
   input  logic                    bp_upd_taken,
   output logic                    out_valid,
   output logic [31:0]             out_inst,
   output logic [ADDR_W-1:0]       out_pc,
   output logic                    out_pred_taken,
   output logic                    mem_req_valid,
   output logic [ADDR_W-1:0]       mem_req_addr,
   input  logic                    mem_resp_valid,
   input  logic [BLK_WORDS*32-1:0] mem_resp_data
);

   localparam int OFF_W = $clog2(BLK_WORDS);
   localparam int IDX_W = $clog2(NUM_BLKS);
   localparam int BHT_W = $clog2(BHT_ENTRIES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {S_IDLE, S_MISS} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [ADDR_W-1:0]        r_pc;
   logic [NUM_BLKS-1:0]      r_valid;
   logic [TAG_W-1:0]         r_tag  [NUM_BLKS];
   logic [BLK_WORDS*32-1:0]  r_data [NUM_BLKS];
   logic [1:0]               r_bht  [BHT_ENTRIES];
   logic                     r_out_vld;
   logic [31:0]              r_out_inst;
   logic [ADDR_W-1:0]        r_out_pc;
   logic                     r_out_pred;
   logic                     r_req_vld;
   logic [ADDR_W-1:0]        r_req_addr;

   logic [OFF_W-1:0]         w_off;
   logic [IDX_W-1:0]         w_idx;
   logic [TAG_W-1:0]         w_tag;
   logic [BHT_W-1:0]         w_bht_idx;
   logic [BHT_W-1:0]         w_upd_idx;
   logic [IDX_W-1:0]         w_req_idx;
   logic [TAG_W-1:0]         w_req_tag;
   logic                     w_hit;
   logic                     w_issue;
   logic                     w_fill;
   logic                     w_start_miss;
   logic [31:0]              w_word;
   logic [ADDR_W-1:0]        w_jimm;
   logic [ADDR_W-1:0]        w_bimm;
   logic                     w_pred;
   logic [ADDR_W-1:0]        w_pc_nxt;
   logic                     w_unused;

   assign w_off     = r_pc[OFF_W+1:2];
   assign w_idx     = r_pc[OFF_W+IDX_W+1:OFF_W+2];
   assign w_tag     = r_pc[ADDR_W-1:OFF_W+IDX_W+2];
   assign w_bht_idx = r_pc[BHT_W+1:2];
   assign w_upd_idx = bp_upd_pc[BHT_W+1:2];
   assign w_req_idx = r_req_addr[OFF_W+IDX_W+1:OFF_W+2];
   assign w_req_tag = r_req_addr[ADDR_W-1:OFF_W+IDX_W+2];
   assign w_unused  = ^{bp_upd_pc[ADDR_W-1:BHT_W+2], bp_upd_pc[1:0], r_req_addr[OFF_W+1:0]};

   assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_issue = w_hit && !stall && !redirect_valid;
   assign w_word  = r_data[w_idx][{w_off, 5'b00000} +: 32];

   assign w_jimm = {{(ADDR_W-21){w_word[31]}}, w_word[31], w_word[19:12], w_word[20],
                    w_word[30:21], 1'b0};
   assign w_bimm = {{(ADDR_W-13){w_word[31]}}, w_word[31], w_word[7], w_word[30:25],
                    w_word[11:8], 1'b0};

   always_comb begin
      w_pred   = 1'b0;
      w_pc_nxt = r_pc + ADDR_W'(4);
      if (w_word[6:0] == OP_JAL) begin
         w_pred   = 1'b1;
         w_pc_nxt = r_pc + w_jimm;
      end else if (w_word[6:0] == OP_BRANCH && r_bht[w_bht_idx][1]) begin
         w_pred   = 1'b1;
         w_pc_nxt = r_pc + w_bimm;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_fill       = 1'b0;
      w_start_miss = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_hit && !redirect_valid) begin
               w_start_miss = 1'b1;
               w_state_nxt  = S_MISS;
            end
         end
         S_MISS: begin
            if (mem_resp_valid) begin
               w_fill      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else if (rdy) begin
         r_state <= w_state_nxt;
      end
   end

   // Redirect outranks issue; an outstanding refill keeps running across it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc       <= RESET_PC;
         r_out_vld  <= 1'b0;
         r_out_inst <= '0;
         r_out_pc   <= '0;
         r_out_pred <= 1'b0;
         r_req_vld  <= 1'b0;
         r_req_addr <= '0;
         r_valid    <= '0;
      end else if (rdy) begin
         r_out_vld <= w_issue;
         if (redirect_valid) begin
            r_pc <= redirect_pc;
         end else if (w_issue) begin
            r_pc       <= w_pc_nxt;
            r_out_inst <= w_word;
            r_out_pc   <= r_pc;
            r_out_pred <= w_pred;
         end
         if (w_start_miss) begin
            r_req_vld  <= 1'b1;
            r_req_addr <= {r_pc[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
         end else if (w_fill) begin
            r_req_vld          <= 1'b0;
            r_valid[w_req_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rdy && w_fill) begin
         r_tag[w_req_idx]  <= w_req_tag;
         r_data[w_req_idx] <= mem_resp_data;
      end
   end

   // Counters start weakly not-taken; a same-cycle lookup sees the pre-update value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
      end else if (rdy && bp_upd_valid) begin
         if (bp_upd_taken && r_bht[w_upd_idx] != 2'b11)
            r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
         else if (!bp_upd_taken && r_bht[w_upd_idx] != 2'b00)
            r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
      end
   end

   assign out_valid      = r_out_vld;
   assign out_inst       = r_out_inst;
   assign out_pc         = r_out_pc;
   assign out_pred_taken = r_out_pred;
   assign mem_req_valid  = r_req_vld;
   assign mem_req_addr   = r_req_addr;

endmodule
